mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares the single 4-byte-lane memory port between the instruction-fetch requester and the data (lw/sw) requester of the MIPS core. It serialises accesses, holds the address stable for the memory's fixed read latency, and returns read data or write acknowledgement to the winning requester. It sits between the fetch/control logic and the memory model, replacing direct drive of `mem_addr`, `mem_data_in` and `mem_write_en` by the control unit.

## Interface
- `MEM_LATENCY`, default 1: memory read latency in cycles; legal range 1..15.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `halted` in 1: core halted (syscall or illegal opcode); blocks new grants.
- `if_req` in 1: fetch request; held until granted.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: fetched instruction word.
- `dm_req` in 1: data request; held until granted.
- `dm_we` in 1: 1 = store word, 0 = load word.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: store data.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1: one-cycle pulse; load data or store acknowledgement.
- `dm_rdata` out 32: load data; 0 for stores and errors.
- `dm_err` out 1: coincides with `dm_rvalid` when `dm_addr[1:0]` is not 0.
- `mem_addr` out 32: memory address.
- `mem_data_in` out 8 x [0:3]: write lanes; lane 0 = bits 7:0.
- `mem_write_en` out 1: memory write strobe.
- `mem_data_out` in 8 x [0:3]: read lanes; lane 0 = bits 7:0.
- `busy` out 1: an access is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE with `halted`=0 and at least one request:
  - Select the winner and assert its `*_gnt` combinationally in that cycle.
  - Register owner, address, `we` and wdata.
  - Load latency counter to 0 and go to ACCESS.
- IDLE with `halted`=1: no grant, no state change.
- ACCESS:
  - `mem_addr` = registered address. `mem_write_en` = 1 only in the first ACCESS cycle of a store.
  - Store: go to RESP after 1 cycle.
  - Load/fetch: count up. When count = `MEM_LATENCY`-1, capture `{mem_data_out[3],[2],[1],[0]}` into the response register and go to RESP.
- RESP: pulse the owner's `*_rvalid` with the response register, then go to IDLE.
- Misaligned data access (`dm_addr[1:0]` not 0):
  - Granted normally.
  - ACCESS is skipped: no `mem_write_en` pulse, and `mem_addr` is not updated.
  - Goes directly to RESP with `dm_err`=1 and `dm_rdata`=0.
- Fetch addresses are not checked; bits 1:0 are forced to 0 on `mem_addr`.
- Fixed priority (default): data beats fetch when both request.
- `mem_data_in` lanes = registered wdata little-endian; driven 0 when not a store.
- `halted` rising mid-access: the access completes and responds normally; no further grants.

## Timing
- Reset: state IDLE, all outputs 0 (`mem_addr`, `mem_data_in`, `*_rdata`, strobes, `busy`); counter 0; round-robin pointer = data-first.
- Reset mid-access aborts it: no `rvalid`; `mem_write_en` is 0 from the next cycle.
- Load/fetch: grant at cycle T, capture at T+`MEM_LATENCY`, `rvalid` at T+`MEM_LATENCY`+1.
- Store: grant at T, `mem_write_en` at T+1, `rvalid` at T+2.
- Misaligned: grant at T, `rvalid`/`dm_err` at T+1.
- Grants are issued only in IDLE, so the minimum spacing is `MEM_LATENCY`+2 cycles for reads and 3 for stores.
- A request that drops before grant is simply not served. Requests are not queued.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - Under contention, the requester not granted last wins.
  - A lone requester always wins and updates the pointer.
- `MEM_ARB_RR_EN` undefined: fixed data-over-fetch priority. The pointer logic is absent.

## Test plan
- Reset, then `if_req` with `if_addr`=0x40 and memory word 0x2008_0005, `MEM_LATENCY`=3 -> `if_gnt` at T, `mem_addr`=0x40 for T+1..T+3, `if_rvalid` with `if_rdata`=0x2008_0005 at T+4.
- Store with `dm_addr`=0x100 and `dm_wdata`=0xDEAD_BEEF -> `mem_write_en` high for exactly one cycle with lanes [0..3]=EF,BE,AD,DE; `dm_rvalid` at T+2 with `dm_rdata`=0.
- `if_req` and `dm_req` both held high for 4 grants:
  - Without `MEM_ARB_RR_EN`: data granted every time.
  - With `MEM_ARB_RR_EN`: grants alternate data, fetch, data, fetch.
- Load with `dm_addr`=0x102 -> `dm_err`=1 and `dm_rdata`=0 at T+1; no `mem_write_en` pulse; `mem_addr` unchanged.
- Assert `halted` during the ACCESS of a load -> that load's `dm_rvalid` still fires; subsequent held requests get no grant; `busy`=0 afterwards.
- Assert `rst` for 1 cycle mid-ACCESS of a fetch -> no `if_rvalid`; all outputs 0 the next cycle; a new request is granted the cycle after `rst` deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one 4-lane memory port between instruction fetch and data load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halted,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [0:3],
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_out [0:3],
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic        owner_dm;
    logic        we_q;
    logic [3:0]  cnt;
    logic        pick_dm;
    logic        grant;
    logic        misalign;
    logic [31:0] rd_word;

    always_comb begin
        rd_word  = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
        misalign = |dm_addr[1:0];
    end

`ifdef MEM_ARB_RR_EN
    logic prefer_dm;

    // Under contention the requester not granted last wins; a lone winner still moves the pointer.
    always_comb pick_dm = dm_req && (!if_req || prefer_dm);

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_dm <= 1'b1;
        end else if (grant) begin
            prefer_dm <= !pick_dm;
        end
    end
`else
    always_comb pick_dm = dm_req;
`endif

    always_comb begin
        grant  = (state == IDLE) && !halted && !rst && (if_req || dm_req);
        dm_gnt = grant && pick_dm;
        if_gnt = grant && !pick_dm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner_dm     <= 1'b0;
            we_q         <= 1'b0;
            cnt          <= '0;
            busy         <= 1'b0;
            mem_addr     <= '0;
            mem_write_en <= 1'b0;
            mem_data_in  <= '{default: '0};
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            dm_rvalid    <= 1'b0;
            dm_rdata     <= '0;
            dm_err       <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            dm_rvalid    <= 1'b0;
            dm_rdata     <= '0;
            dm_err       <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner_dm <= pick_dm;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (pick_dm && misalign) begin
                            // Misaligned data access never touches the port; respond next cycle.
                            state     <= RESP;
                            we_q      <= dm_we;
                            dm_rvalid <= 1'b1;
                            dm_err    <= 1'b1;
                        end else if (pick_dm) begin
                            state    <= ACCESS;
                            mem_addr <= dm_addr;
                            we_q     <= dm_we;
                            if (dm_we) begin
                                mem_write_en <= 1'b1;
                                for (int unsigned i = 0; i < 4; i++) begin
                                    mem_data_in[i] <= dm_wdata[8*i +: 8];
                                end
                            end
                        end else begin
                            state    <= ACCESS;
                            mem_addr <= if_addr & ~32'h3;
                            we_q     <= 1'b0;
                        end
                    end
                end

                ACCESS: begin
                    if (we_q) begin
                        state       <= RESP;
                        mem_data_in <= '{default: '0};
                        dm_rvalid   <= 1'b1;
                    end else if (cnt == LAST_CNT) begin
                        state <= RESP;
                        if (owner_dm) begin
                            dm_rvalid <= 1'b1;
                            dm_rdata  <= rd_word;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= rd_word;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard of responses,
// and hand sequences for contention, halt and mid-access reset.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 3;
    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [0:3];
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .halted       (halted),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_gnt       (dm_gnt),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .dm_err       (dm_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    // Read-only memory model, word-indexed by mem_addr[9:2].
    logic [31:0] mem [0:255];
    logic [31:0] rd_word;
    assign rd_word         = mem[mem_addr[9:2]];
    assign mem_data_out[0] = rd_word[7:0];
    assign mem_data_out[1] = rd_word[15:8];
    assign mem_data_out[2] = rd_word[23:16];
    assign mem_data_out[3] = rd_word[31:24];

    logic [31:0] lanes;
    assign lanes = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_write_en) wr_cnt = wr_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        dm;
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (if_rvalid || dm_rvalid) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid_owner", {30'b0, if_rvalid, dm_rvalid}, mon_e.dm ? 32'd1 : 32'd2);
                chk("rdata", mon_e.dm ? dm_rdata : if_rdata, mon_e.rdata);
                chk("dm_err", {31'b0, dm_err}, {31'b0, mon_e.err});
                chk("resp_latency", 32'(cyc - mon_e.gcyc), 32'(mon_e.lat));
            end
        end
    end

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int limit, output logic got_if, output logic got_dm, output int waited);
        got_if = 1'b0;
        got_dm = 1'b0;
        waited = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (if_gnt || dm_gnt) begin
                got_if = if_gnt;
                got_dm = dm_gnt;
                return;
            end
            waited++;
        end
    endtask

    task automatic push_exp(input logic dm, input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.dm    = dm;
        e.rdata = rdata;
        e.err   = err;
        e.gcyc  = cyc;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
        chk({name, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
        chk({name, "_mem_addr"}, mem_addr, 32'd0);
        chk({name, "_we"}, {31'b0, mem_write_en}, 32'd0);
        chk({name, "_lanes"}, lanes, 32'd0);
        chk({name, "_rvalid"}, {29'b0, if_rvalid, dm_rvalid, dm_err}, 32'd0);
        chk({name, "_if_rdata"}, if_rdata, 32'd0);
        chk({name, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        gi, gd;
        int          waited;
        int          wr_before;
        int          prev_g;
        logic [31:0] last_addr;
        logic [31:0] exp_a;
        logic [1:0]  exp_g;
        logic        mis;
        int          lat;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0BAD_0000 | 32'(i);
        mem[8'h10] = 32'h2008_0005;
        mem[8'h11] = 32'h8C0A_0010;
        mem[8'h40] = 32'h1122_3344;
        mem[8'h80] = 32'hCAFE_F00D;

        //            dm    we    addr         wdata         exp_rdata     err
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h2008_0005, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0047, 32'h0,        32'h8C0A_0010, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h1122_3344, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,        32'h0,         1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0203, 32'h1234_5678, 32'h0,        1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0202, 32'h0,        32'hCAFE_F00D, 1'b0};

        rst = 1'b1; halted = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_gnt", {30'b0, if_gnt, dm_gnt}, 32'd0);
        step();
        rst = 1'b0;

        // Single-requester transactions from the vector table.
        last_addr = '0;
        for (int unsigned v = 0; v < NV; v++) begin
            mis = vecs[v].dm && (vecs[v].addr[1:0] != 2'b00);
            if (vecs[v].dm) begin
                dm_req = 1'b1; dm_we = vecs[v].we; dm_addr = vecs[v].addr; dm_wdata = vecs[v].wdata;
            end else begin
                if_req = 1'b1; if_addr = vecs[v].addr;
            end
            wr_before = wr_cnt;
            wait_gnt(10, gi, gd, waited);
            chk("vec_gnt", {30'b0, gi, gd}, vecs[v].dm ? 32'd1 : 32'd2);
            chk("vec_gnt_wait", 32'(waited), 32'd0);
            lat = mis ? 1 : (vecs[v].dm && vecs[v].we) ? 2 : int'(LAT) + 1;
            push_exp(vecs[v].dm, vecs[v].exp_rdata, vecs[v].exp_err, lat);
            step();
            if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
            if (mis) begin
                @(negedge clk);
                chk("mis_addr_hold", mem_addr, last_addr);
                chk("mis_no_we", {31'b0, mem_write_en}, 32'd0);
            end else if (vecs[v].dm && vecs[v].we) begin
                @(negedge clk);
                chk("st_we", {31'b0, mem_write_en}, 32'd1);
                chk("st_addr", mem_addr, vecs[v].addr);
                chk("st_lanes", lanes, vecs[v].wdata);
                @(negedge clk);
                chk("st_we_off", {31'b0, mem_write_en}, 32'd0);
                chk("st_lanes_off", lanes, 32'd0);
                last_addr = vecs[v].addr;
            end else begin
                exp_a = vecs[v].addr & ~32'h3;
                for (int unsigned k = 0; k < LAT; k++) begin
                    @(negedge clk);
                    chk("rd_addr", mem_addr, exp_a);
                    chk("rd_no_we", {31'b0, mem_write_en}, 32'd0);
                end
                last_addr = exp_a;
            end
            drain("vec");
            chk("vec_writes", 32'(wr_cnt - wr_before), (vecs[v].we && !mis) ? 32'd1 : 32'd0);
            step();
        end

        // Both requesters held for four grants.
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_addr = 32'h40; dm_addr = 32'h200; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        prev_g = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(int'(LAT) + 6, gi, gd, waited);
`ifdef MEM_ARB_RR_EN
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk("cont_gnt", {30'b0, gi, gd}, {30'b0, exp_g});
            if (g > 0) chk("cont_spacing", 32'(cyc - prev_g), 32'(LAT + 2));
            prev_g = cyc;
            push_exp(exp_g[0], exp_g[0] ? 32'hCAFE_F00D : 32'h2008_0005, 1'b0, int'(LAT) + 1);
        end
        step();
        if_req = 1'b0; dm_req = 1'b0;
        drain("cont");
        step();

        // Halt raised during a load's ACCESS.
        dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0;
        wait_gnt(10, gi, gd, waited);
        chk("halt_first_gnt", {30'b0, gi, gd}, 32'd1);
        push_exp(1'b1, 32'hCAFE_F00D, 1'b0, int'(LAT) + 1);
        step();
        halted = 1'b1; if_req = 1'b1; if_addr = 32'h44; dm_addr = 32'h100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("halt_no_gnt", {30'b0, if_gnt, dm_gnt}, 32'd0);
        end
        chk("halt_busy", {31'b0, busy}, 32'd0);
        chk("halt_sb", 32'(sb.size()), 32'd0);
        step();
        if_req = 1'b0; dm_req = 1'b0; halted = 1'b0;
        step();

        // Reset pulse in the middle of a fetch.
        if_req = 1'b1; if_addr = 32'h40;
        wait_gnt(10, gi, gd, waited);
        chk("rstmid_gnt", {30'b0, gi, gd}, 32'd2);
        step();
        if_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_access_addr", mem_addr, 32'h40);
        chk("rstmid_access_busy", {31'b0, busy}, 32'd1);
        step();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        chk_outputs_zero("rstmid");
        chk("rstmid_regrant", {30'b0, if_gnt, dm_gnt}, 32'd2);
        push_exp(1'b0, 32'h8C0A_0010, 1'b0, int'(LAT) + 1);
        step();
        if_req = 1'b0;
        drain("rstmid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
